// File: rtl/freq_counter.sv
// Gated frequency counter: counts ce events between successive ovf strobes, latching the total to freq.
// Latency: freq/sat/valid register on the edge that samples ovf=1; no backpressure, since every strobe is reported.
module freq_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ce,
  input  logic             ovf,
  output logic [WIDTH-1:0] freq,
  output logic             valid,
  output logic             sat
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] cnt;
  logic             sat_int;
  logic             at_max;

  assign at_max = (cnt == CNT_MAX);

  // A ce in the closing cycle already belongs to the next window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      sat_int <= 1'b0;
    end else if (ovf) begin
      cnt     <= ce ? CNT_ONE : '0;
      sat_int <= 1'b0;
    end else if (ce) begin
      if (at_max) begin
        sat_int <= 1'b1;
      end else begin
        cnt <= cnt + CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      freq  <= '0;
      sat   <= 1'b0;
      valid <= 1'b0;
    end else begin
      valid <= ovf;
      if (ovf) begin
        freq <= cnt;
        sat  <= sat_int;
      end
    end
  end

endmodule

// File: tb/tb_freq_counter.sv
// Bench for freq_counter: a 16-bit and a 4-bit instance share stimulus and are checked against an event-count model.
module tb_freq_counter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce  = 1'b0;
  logic        ovf = 1'b0;
  logic [15:0] freq16;
  logic        valid16, sat16;
  logic [3:0]  freq4;
  logic        valid4, sat4;

  int tests = 0;
  int fails = 0;

  // Model: raw event count of the open window, and the raw count of the last closed one.
  longint raw      = 0;
  longint rep_raw  = 0;
  bit     exp_vld  = 1'b0;

  always #5 clk = ~clk;

  freq_counter #(.WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .ce(ce), .ovf(ovf),
    .freq(freq16), .valid(valid16), .sat(sat16)
  );

  freq_counter #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .ce(ce), .ovf(ovf),
    .freq(freq4), .valid(valid4), .sat(sat4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    longint max16 = 65535;
    longint max4  = 15;
    check({tag, " freq16"},  {16'd0, freq16}, (rep_raw > max16) ? 32'(max16) : 32'(rep_raw));
    check({tag, " sat16"},   {31'd0, sat16},  {31'd0, rep_raw > max16});
    check({tag, " valid16"}, {31'd0, valid16}, {31'd0, exp_vld});
    check({tag, " freq4"},   {28'd0, freq4},  (rep_raw > max4) ? 32'(max4) : 32'(rep_raw));
    check({tag, " sat4"},    {31'd0, sat4},   {31'd0, rep_raw > max4});
    check({tag, " valid4"},  {31'd0, valid4}, {31'd0, exp_vld});
  endtask

  task automatic model_reset();
    raw     = 0;
    rep_raw = 0;
    exp_vld = 1'b0;
  endtask

  // Inputs are applied 1 time unit after a rising edge and outputs checked 1 unit after the next.
  task automatic step(input string tag, input logic c, input logic o);
    ce  = c;
    ovf = o;
    @(posedge clk);
    if (o) begin
      rep_raw = raw;
      exp_vld = 1'b1;
      raw     = c ? 1 : 0;
    end else begin
      exp_vld = 1'b0;
      if (c) raw++;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Power-on reset, asserted away from any clock edge.
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("por");
    @(posedge clk);
    #1 check_all("por_hold");
    #2 rst = 1'b0;

    // Continuous enable, strobe every 5th cycle.
    for (int i = 0; i < 20; i++) step("cont", 1'b1, (i % 5) == 4);

    // Enable on alternate cycles, strobe every 10th cycle.
    for (int i = 0; i < 40; i++) step("gated", logic'(i % 2), (i % 10) == 9);

    // Back-to-back strobes with ce held high.
    repeat (3) step("b2b_pre", 1'b1, 1'b0);
    repeat (3) step("b2b", 1'b1, 1'b1);
    repeat (2) step("b2b_post", 1'b1, 1'b0);
    step("b2b_close", 1'b0, 1'b1);

    // Saturate the 4-bit instance, then show the next window clears sat.
    repeat (20) step("sat_fill", 1'b1, 1'b0);
    step("sat_close", 1'b0, 1'b1);
    repeat (3) step("sat_refill", 1'b1, 1'b0);
    step("sat_close2", 1'b0, 1'b1);
    step("sat_idle", 1'b0, 1'b0);

    // No activity: strobes report zero.
    for (int i = 0; i < 15; i++) step("idle", 1'b0, (i % 5) == 4);

    // Random ce and ovf, including stretches where both are the same signal.
    for (int i = 0; i < 400; i++) begin
      logic c, o;
      c = logic'($urandom_range(0, 3) != 0);
      o = logic'($urandom_range(0, 7) == 0);
      if (i >= 300) o = c;
      step("rand", c, o);
    end

    // Reset mid-window with ce high and ovf toggling.
    for (int i = 0; i < 7; i++) step("pre_rst", 1'b1, (i % 3) == 2);
    repeat (4) step("pre_rst_fill", 1'b1, 1'b0);
    #2 rst = 1'b1;
    #1 model_reset();
    check_all("mid_rst");
    for (int i = 0; i < 3; i++) begin
      ce  = 1'b1;
      ovf = ~ovf;
      @(posedge clk);
      #1 check_all("rst_hold");
    end
    #2 rst = 1'b0;
    repeat (6) step("post_rst", 1'b1, 1'b0);
    step("post_rst_close", 1'b0, 1'b1);
    step("post_rst_idle", 1'b0, 1'b0);

    // Random tail after reset.
    for (int i = 0; i < 200; i++) begin
      step("rand2", logic'($urandom_range(0, 1)), logic'($urandom_range(0, 5) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
